// File: rtl/conv_layer_mem_pkg.sv
// Shared definitions for conv_layer_mem: layer-select codes, bank depths and run-FSM states.
package conv_layer_mem_pkg;

   localparam logic [2:0] CSEL_NONE = 3'b000;
   localparam logic [2:0] CSEL_L0   = 3'b001;
   localparam logic [2:0] CSEL_L1   = 3'b011;

   localparam int unsigned IMG_DEPTH = 4096;
   localparam int unsigned L0_DEPTH  = 4096;
   localparam int unsigned L1_DEPTH  = 1024;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StWaitBusy,
      StRun,
      StDone
   } state_t;

   function automatic logic csel_valid(input logic [2:0] sel);
      return (sel == CSEL_L0) || (sel == CSEL_L1);
   endfunction

endpackage

// File: rtl/conv_mem_bank.sv
// Generic storage bank: one synchronous write port and two asynchronous read ports.
// Contents are not reset, so data survives a reset of the surrounding block.
module conv_mem_bank #(
   parameter int unsigned Depth = 4096,
   parameter int unsigned Width = 20,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AddrW-1:0] waddr,
   input  logic [Width-1:0] wdata,
   input  logic [AddrW-1:0] raddr_a,
   output logic [Width-1:0] rdata_a,
   input  logic [AddrW-1:0] raddr_b,
   output logic [Width-1:0] rdata_b
);

   logic [Width-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Reads see the pre-write contents during a same-cycle write to the same address.
   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/conv_layer_mem.sv
// Memory responder for the convolution engine: image, L0 and L1 banks plus the run handshake.
// Define CONV_LAYER_MEM_CHECK_EN to build the sticky protocol-error detector driving err.
module conv_layer_mem
   import conv_layer_mem_pkg::*;
#(
   parameter int unsigned DW    = 20,
   parameter int unsigned AW    = 12,
   parameter int unsigned L1_AW = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   input  logic          start,
   output logic          ready,
   input  logic          busy,
   input  logic [AW-1:0] iaddr,
   output logic [DW-1:0] idata,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic [2:0]    csel,
   output logic          done,
   input  logic          dump_req,
   input  logic [2:0]    dump_sel,
   input  logic [AW-1:0] dump_addr,
   output logic [DW-1:0] dump_data,
   output logic          dump_valid,
   output logic          err
);

   state_t state_q, state_d;

   logic          ready_q, ld_ready_q, done_q;
   logic          dump_valid_q;
   logic [DW-1:0] dump_data_q, cdata_q;

   logic          img_we, l0_we, l1_we, wr_window, l1_hi_ok, dump_ok;
   logic [DW-1:0] img_rdata_unused;
   logic [DW-1:0] l0_rd, l0_dump, l1_rd, l1_dump;
   logic [DW-1:0] rd_mux, dump_mux;

   // ---------------------------------------------------------------- run FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StArm;
         StArm:          state_d = StWaitBusy;
         StWaitBusy:     if (busy) state_d = StRun;
         StRun:          if (!busy) state_d = StDone;
         default:        state_d = StIdle;
      endcase
   end

   // Handshake outputs are registered from the next state so they read 0 while in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ready_q    <= 1'b0;
         ld_ready_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= (state_d == StArm);
         ld_ready_q <= (state_d == StIdle) || (state_d == StDone);
         done_q     <= (state_d == StDone);
      end
   end

   assign ready    = ready_q;
   assign ld_ready = ld_ready_q;
   assign done     = done_q;

   // ---------------------------------------------------------------- write qualification
   assign img_we    = ld_valid & ld_ready_q;
   assign wr_window = (state_q == StWaitBusy) || (state_q == StRun);
   assign l1_hi_ok  = (caddr_wr[AW-1:L1_AW] == '0);
   assign l0_we     = cwr & wr_window & (csel == CSEL_L0);
   assign l1_we     = cwr & wr_window & (csel == CSEL_L1) & l1_hi_ok;

   // ---------------------------------------------------------------- banks
   conv_mem_bank #(
      .Depth (IMG_DEPTH),
      .Width (DW)
   ) u_img (
      .clk     (clk),
      .we      (img_we),
      .waddr   (ld_addr),
      .wdata   (ld_data),
      .raddr_a (iaddr),
      .rdata_a (idata),
      .raddr_b (ld_addr),
      .rdata_b (img_rdata_unused)
   );

   conv_mem_bank #(
      .Depth (L0_DEPTH),
      .Width (DW)
   ) u_l0 (
      .clk     (clk),
      .we      (l0_we),
      .waddr   (caddr_wr),
      .wdata   (cdata_wr),
      .raddr_a (caddr_rd),
      .rdata_a (l0_rd),
      .raddr_b (dump_addr),
      .rdata_b (l0_dump)
   );

   conv_mem_bank #(
      .Depth (L1_DEPTH),
      .Width (DW)
   ) u_l1 (
      .clk     (clk),
      .we      (l1_we),
      .waddr   (caddr_wr[L1_AW-1:0]),
      .wdata   (cdata_wr),
      .raddr_a (caddr_rd[L1_AW-1:0]),
      .rdata_a (l1_rd),
      .raddr_b (dump_addr[L1_AW-1:0]),
      .rdata_b (l1_dump)
   );

   // ---------------------------------------------------------------- engine layer read
   always_comb begin
      rd_mux = '0;
      if (csel == CSEL_L0) begin
         rd_mux = l0_rd;
      end else if (csel == CSEL_L1) begin
         rd_mux = l1_rd;
      end
   end

   // cdata_rd is live while crd is high and otherwise holds the last value read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cdata_q <= '0;
      end else if (crd) begin
         cdata_q <= rd_mux;
      end
   end

   assign cdata_rd = crd ? rd_mux : cdata_q;

   // ---------------------------------------------------------------- host dump
   always_comb begin
      dump_mux = '0;
      if (dump_sel == CSEL_L0) begin
         dump_mux = l0_dump;
      end else if (dump_sel == CSEL_L1) begin
         dump_mux = l1_dump;
      end
   end

   assign dump_ok = dump_req & (state_q == StDone);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dump_valid_q <= 1'b0;
         dump_data_q  <= '0;
      end else begin
         dump_valid_q <= dump_ok;
         if (dump_ok) begin
            dump_data_q <= dump_mux;
         end
      end
   end

   assign dump_valid = dump_valid_q;
   assign dump_data  = dump_data_q;

   // ---------------------------------------------------------------- protocol checker
`ifdef CONV_LAYER_MEM_CHECK_EN
   logic err_q, err_hit;

   assign err_hit = (cwr & ~csel_valid(csel))
                  | (cwr & (csel == CSEL_L1) & ~l1_hi_ok)
                  | (crd & ~csel_valid(csel))
                  | (dump_req & ~csel_valid(dump_sel))
                  | (cwr & ~wr_window);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (err_hit) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_mem.sv
// Directed self-checking bench for conv_layer_mem: load, run handshake, layer access, dump, reset.
module tb_conv_layer_mem;

`ifdef CONV_LAYER_MEM_CHECK_EN
   localparam logic ErrExp = 1'b1;
`else
   localparam logic ErrExp = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ld_valid, start, busy, cwr, crd, dump_req;
   logic [11:0] ld_addr, iaddr, caddr_wr, caddr_rd, dump_addr;
   logic [19:0] ld_data, cdata_wr;
   logic [2:0]  csel, dump_sel;
   logic        ld_ready, ready, done, dump_valid, err;
   logic [19:0] idata, cdata_rd, dump_data;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   conv_layer_mem dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .start      (start),
      .ready      (ready),
      .busy       (busy),
      .iaddr      (iaddr),
      .idata      (idata),
      .cwr        (cwr),
      .caddr_wr   (caddr_wr),
      .cdata_wr   (cdata_wr),
      .crd        (crd),
      .caddr_rd   (caddr_rd),
      .cdata_rd   (cdata_rd),
      .csel       (csel),
      .done       (done),
      .dump_req   (dump_req),
      .dump_sel   (dump_sel),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_valid (dump_valid),
      .err        (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset_n  = 1'b0;
      ld_valid = 1'b0; ld_addr  = '0; ld_data   = '0;
      start    = 1'b0; busy     = 1'b0; iaddr   = '0;
      cwr      = 1'b0; caddr_wr = '0; cdata_wr  = '0;
      crd      = 1'b0; caddr_rd = '0; csel      = 3'b000;
      dump_req = 1'b0; dump_sel = 3'b000; dump_addr = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_ld_ready", 32'(ld_ready), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_dump_valid", 32'(dump_valid), 32'h0);
      check("rst_cdata_rd", 32'(cdata_rd), 32'h0);
      check("rst_dump_data", 32'(dump_data), 32'h0);
      reset_n = 1'b1;
      settle();
      check("ld_ready_at_release", 32'(ld_ready), 32'h0);
      @(negedge clk);
      check("ld_ready_idle", 32'(ld_ready), 32'h1);

      // Image preload img[a] = a
      for (int a = 0; a < 4096; a++) begin
         ld_valid = 1'b1;
         ld_addr  = 12'(a);
         ld_data  = 20'(a);
         @(negedge clk);
      end
      ld_valid = 1'b0;

      // Run handshake
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ready_pulse", 32'(ready), 32'h1);
      check("ld_ready_arm", 32'(ld_ready), 32'h0);
      @(negedge clk);
      check("ready_one_cycle", 32'(ready), 32'h0);
      busy = 1'b1;
      @(negedge clk);

      // RUN: image reads
      iaddr = 12'h041;
      settle();
      check("idata_041", 32'(idata), 32'h00041);
      iaddr = 12'hFFF;
      settle();
      check("idata_fff", 32'(idata), 32'h00FFF);

      // Dump outside DONE is ignored; seed L0[0x123]
      dump_req = 1'b1; dump_sel = 3'b001; dump_addr = 12'h000;
      cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h123; cdata_wr = 20'h11111;
      @(negedge clk);
      dump_req = 1'b0;
      check("dump_in_run", 32'(dump_valid), 32'h0);

      // Same-cycle read of the address being written returns the old word
      cdata_wr = 20'h0ABCD;
      crd = 1'b1; caddr_rd = 12'h123;
      settle();
      check("rw_same_old", 32'(cdata_rd), 32'h11111);
      @(negedge clk);
      cwr = 1'b0;
      settle();
      check("l0_rd_new", 32'(cdata_rd), 32'h0ABCD);
      @(negedge clk);
      crd = 1'b0; caddr_rd = 12'h000;
      settle();
      check("cdata_hold", 32'(cdata_rd), 32'h0ABCD);

      // L1 top address
      cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h3FF; cdata_wr = 20'hFFFFF;
      @(negedge clk);
      cwr = 1'b0;
      crd = 1'b1; caddr_rd = 12'h3FF;
      settle();
      check("l1_rd_3ff", 32'(cdata_rd), 32'hFFFFF);
      check("err_clean", 32'(err), 32'h0);

      // Illegal writes must not touch any bank
      crd = 1'b0;
      cwr = 1'b1; csel = 3'b010; caddr_wr = 12'h123; cdata_wr = 20'h55555;
      @(negedge clk);
      csel = 3'b011; caddr_wr = 12'h7FF; cdata_wr = 20'h12345;
      @(negedge clk);
      cwr = 1'b0;
      crd = 1'b1; csel = 3'b001; caddr_rd = 12'h123;
      settle();
      check("l0_kept", 32'(cdata_rd), 32'h0ABCD);
      csel = 3'b011; caddr_rd = 12'h3FF;
      settle();
      check("l1_kept", 32'(cdata_rd), 32'hFFFFF);
      check("err_after_bad_wr", 32'(err), 32'(ErrExp));
      csel = 3'b010;
      settle();
      check("rd_bad_csel", 32'(cdata_rd), 32'h0);
      @(negedge clk);
      crd = 1'b0; csel = 3'b000;

      // Loads during RUN are refused
      ld_valid = 1'b1; ld_addr = 12'h041; ld_data = 20'h99999;
      settle();
      check("ld_ready_run", 32'(ld_ready), 32'h0);
      @(negedge clk);
      ld_valid = 1'b0;
      iaddr = 12'h041;
      settle();
      check("img_unchanged", 32'(idata), 32'h00041);

      // Engine finishes
      busy = 1'b0;
      settle();
      check("done_not_yet", 32'(done), 32'h0);
      @(negedge clk);
      check("done_set", 32'(done), 32'h1);
      check("ld_ready_done", 32'(ld_ready), 32'h1);

      // Back-to-back dumps
      dump_req = 1'b1; dump_sel = 3'b011; dump_addr = 12'h3FF;
      @(negedge clk);
      check("dump1_valid", 32'(dump_valid), 32'h1);
      check("dump1_data", 32'(dump_data), 32'hFFFFF);
      dump_sel = 3'b001; dump_addr = 12'h123;
      @(negedge clk);
      dump_req = 1'b0;
      check("dump2_valid", 32'(dump_valid), 32'h1);
      check("dump2_data", 32'(dump_data), 32'h0ABCD);
      @(negedge clk);
      check("dump_pulse_end", 32'(dump_valid), 32'h0);
      check("err_sticky", 32'(err), 32'(ErrExp));

      // Second run, then reset in the middle of it
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_cleared", 32'(done), 32'h0);
      busy = 1'b1;
      repeat (2) @(negedge clk);
      iaddr = 12'h000;
      reset_n = 1'b0;
      busy = 1'b0;
      settle();
      check("mid_rst_ready", 32'(ready), 32'h0);
      check("mid_rst_ld_ready", 32'(ld_ready), 32'h0);
      check("mid_rst_done", 32'(done), 32'h0);
      check("mid_rst_err", 32'(err), 32'h0);
      check("mid_rst_dump_valid", 32'(dump_valid), 32'h0);
      check("mid_rst_dump_data", 32'(dump_data), 32'h0);
      check("mid_rst_cdata_rd", 32'(cdata_rd), 32'h0);
      check("mid_rst_idata", 32'(idata), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ld_ready", 32'(ld_ready), 32'h1);
      check("post_rst_ready", 32'(ready), 32'h0);
      crd = 1'b1; csel = 3'b001; caddr_rd = 12'h123;
      iaddr = 12'h041;
      settle();
      check("l0_retained", 32'(cdata_rd), 32'h0ABCD);
      check("img_retained", 32'(idata), 32'h00041);
      @(negedge clk);
      crd = 1'b0; csel = 3'b000;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
